// File: rtl/ant_symbol_bank_buffer_if.sv
// Handshake/data bundle between the CPRI RX unpacker, the symbol bank buffer and
// the PUSCH dimension-reduction core.
interface ant_symbol_bank_buffer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int NUM_BANKS  = 2
);
    localparam int LEVEL_W = $clog2(NUM_BANKS) + 1;

    logic [NUM_CH*DATA_WIDTH-1:0] i_rx_data;
    logic                         i_rvalid;
    logic [3:0]                   i_skip_syms;
    logic                         i_rready;
    logic [NUM_CH*DATA_WIDTH-1:0] o_tx_data;
    logic [ADDR_WIDTH-1:0]        o_tx_addr;
    logic [7:0]                   o_tx_sym;
    logic                         o_tx_last;
    logic                         o_tvalid;
    logic                         o_overflow;
    logic [LEVEL_W-1:0]           o_level;

    modport master (
        output i_rx_data, i_rvalid, i_skip_syms, i_rready,
        input  o_tx_data, o_tx_addr, o_tx_sym, o_tx_last, o_tvalid, o_overflow, o_level
    );

    modport slave (
        input  i_rx_data, i_rvalid, i_skip_syms, i_rready,
        output o_tx_data, o_tx_addr, o_tx_sym, o_tx_last, o_tvalid, o_overflow, o_level
    );
endinterface

// File: rtl/ant_symbol_bank_buffer.sv
// Multi-bank, multi-antenna symbol buffer: whole symbols are written round-robin into
// banks and drained in order with sequence index, symbol count and last flag.
module ant_symbol_bank_buffer #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_CH       = 4,
    parameter int SYM_LEN      = 1584,
    parameter int ADDR_WIDTH   = 11,
    parameter int NUM_BANKS    = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    ant_symbol_bank_buffer_if.slave bus
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int LW = BW + 1;
    localparam int MW = BW + ADDR_WIDTH;
    localparam int CW = $clog2(READ_LATENCY + 1) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SYM_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    logic [ADDR_WIDTH-1:0]        wr_cnt_reg;
    logic [BW-1:0]                wr_bank_reg;
    logic                         drop_reg;
    logic [3:0]                   skip_cnt_reg;
    logic                         overflow_reg;
    logic [NUM_BANKS-1:0]         bank_full_reg, bank_full_next;
    logic [LW-1:0]                level_reg;
    state_t                       state_reg, state_next;
    logic [ADDR_WIDTH-1:0]        rd_cnt_reg, rd_cnt_next;
    logic [BW-1:0]                rd_bank_reg, rd_bank_next, rd_bank_inc;
    logic [CW-1:0]                drain_cnt_reg, drain_cnt_next;
    logic                         issue, release_bank;
    logic [READ_LATENCY-1:0]      vld_pipe_reg, last_pipe_reg;
    logic [ADDR_WIDTH-1:0]        addr_pipe_reg [READ_LATENCY];
    logic [NUM_CH*DATA_WIDTH-1:0] ram_q;
    logic [NUM_CH*DATA_WIDTH-1:0] tx_data_reg;
    logic [ADDR_WIDTH-1:0]        tx_addr_reg;
    logic [7:0]                   tx_sym_reg;
    logic                         tx_last_reg, tvalid_reg;

    // The drop decision is taken on word 0 and held for the rest of that symbol.
    logic drop_cur, wr_en, last_word, fill;
    logic [MW-1:0] wr_addr, rd_addr;
    assign drop_cur  = (wr_cnt_reg == '0) ? bank_full_reg[wr_bank_reg] : drop_reg;
    assign wr_en     = bus.i_rvalid && !drop_cur;
    assign last_word = bus.i_rvalid && (wr_cnt_reg == LAST_ADDR);
    assign fill      = last_word && !drop_cur && (skip_cnt_reg == '0);
    assign wr_addr   = {wr_bank_reg, wr_cnt_reg};
    assign rd_addr   = {rd_bank_reg, rd_cnt_reg};
    assign rd_bank_inc = rd_bank_reg + BW'(1);

    always_comb begin
        bank_full_next = bank_full_reg;
        if (release_bank) bank_full_next[rd_bank_reg] = 1'b0;
        if (fill)         bank_full_next[wr_bank_reg] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_cnt_reg    <= '0;
            wr_bank_reg   <= '0;
            drop_reg      <= 1'b0;
            skip_cnt_reg  <= bus.i_skip_syms;
            overflow_reg  <= 1'b0;
            bank_full_reg <= '0;
            level_reg     <= '0;
        end else begin
            if (bus.i_rvalid) begin
                wr_cnt_reg <= (wr_cnt_reg == LAST_ADDR) ? '0 : wr_cnt_reg + ADDR_WIDTH'(1);
                if (wr_cnt_reg == '0) begin
                    drop_reg <= bank_full_reg[wr_bank_reg];
                    if (bank_full_reg[wr_bank_reg]) overflow_reg <= 1'b1;
                end
                if (last_word && !drop_cur && skip_cnt_reg != '0)
                    skip_cnt_reg <= skip_cnt_reg - 4'd1;
            end
            if (fill) wr_bank_reg <= wr_bank_reg + BW'(1);
            bank_full_reg <= bank_full_next;
            level_reg     <= level_reg + LW'(fill) - LW'(release_bank);
        end
    end

    // One RAM per antenna; the read port is always active and followed by a data pipe.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] mem [2**MW];
            logic [DATA_WIDTH-1:0] pipe_reg [READ_LATENCY];
            always_ff @(posedge i_clk) begin
                if (wr_en) mem[wr_addr] <= bus.i_rx_data[gi*DATA_WIDTH +: DATA_WIDTH];
                pipe_reg[0] <= mem[rd_addr];
                for (int i = 1; i < READ_LATENCY; i++) pipe_reg[i] <= pipe_reg[i-1];
            end
            assign ram_q[gi*DATA_WIDTH +: DATA_WIDTH] = pipe_reg[READ_LATENCY-1];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        rd_cnt_next    = rd_cnt_reg;
        rd_bank_next   = rd_bank_reg;
        drain_cnt_next = drain_cnt_reg;
        issue          = 1'b0;
        release_bank   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (bank_full_reg[rd_bank_reg]) begin
                    state_next  = S_READ;
                    rd_cnt_next = '0;
                end
            end
            S_READ: begin
                if (bus.i_rready) begin
                    issue = 1'b1;
                    if (rd_cnt_reg == LAST_ADDR) begin
                        rd_cnt_next    = '0;
                        drain_cnt_next = '0;
                        state_next     = S_DRAIN;
                    end else begin
                        rd_cnt_next = rd_cnt_reg + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Bank stays occupied until its last word has left the read pipe.
                if (drain_cnt_reg == CW'(READ_LATENCY)) begin
                    release_bank = 1'b1;
                    rd_bank_next = rd_bank_inc;
                    state_next   = bank_full_reg[rd_bank_inc] ? S_READ : S_IDLE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= S_IDLE;
            rd_cnt_reg    <= '0;
            rd_bank_reg   <= '0;
            drain_cnt_reg <= '0;
            vld_pipe_reg  <= '0;
            last_pipe_reg <= '0;
            for (int i = 0; i < READ_LATENCY; i++) addr_pipe_reg[i] <= '0;
            tx_data_reg   <= '0;
            tx_addr_reg   <= '0;
            tx_last_reg   <= 1'b0;
            tvalid_reg    <= 1'b0;
            tx_sym_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            rd_cnt_reg    <= rd_cnt_next;
            rd_bank_reg   <= rd_bank_next;
            drain_cnt_reg <= drain_cnt_next;
            vld_pipe_reg[0]  <= issue;
            last_pipe_reg[0] <= issue && (rd_cnt_reg == LAST_ADDR);
            addr_pipe_reg[0] <= rd_cnt_reg;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe_reg[i]  <= vld_pipe_reg[i-1];
                last_pipe_reg[i] <= last_pipe_reg[i-1];
                addr_pipe_reg[i] <= addr_pipe_reg[i-1];
            end
            tvalid_reg  <= vld_pipe_reg[READ_LATENCY-1];
            tx_last_reg <= last_pipe_reg[READ_LATENCY-1];
            tx_addr_reg <= vld_pipe_reg[READ_LATENCY-1] ? addr_pipe_reg[READ_LATENCY-1] : '0;
            tx_data_reg <= vld_pipe_reg[READ_LATENCY-1] ? ram_q : '0;
            if (tx_last_reg) tx_sym_reg <= tx_sym_reg + 8'd1;
        end
    end

    assign bus.o_tx_data  = tx_data_reg;
    assign bus.o_tx_addr  = tx_addr_reg;
    assign bus.o_tx_sym   = tx_sym_reg;
    assign bus.o_tx_last  = tx_last_reg;
    assign bus.o_tvalid   = tvalid_reg;
    assign bus.o_overflow = overflow_reg;
    assign bus.o_level    = level_reg;
endmodule

// File: tb/tb_ant_symbol_bank_buffer.sv
// Scoreboard bench for ant_symbol_bank_buffer: table of symbol-stream scenarios plus a
// mid-read asynchronous reset sequence.
module tb_ant_symbol_bank_buffer;
    localparam int DW = 64;
    localparam int NC = 4;
    localparam int SL = 1584;
    localparam int AW = 11;
    localparam int NB = 2;
    localparam int RL = 2;
    localparam int LVW = $clog2(NB) + 1;
    localparam int M_ON = 0, M_OFF = 1, M_TOG = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ant_symbol_bank_buffer_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) bus ();

    ant_symbol_bank_buffer #(
        .DATA_WIDTH(DW), .NUM_CH(NC), .SYM_LEN(SL), .ADDR_WIDTH(AW),
        .NUM_BANKS(NB), .READ_LATENCY(RL)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [NC*DW-1:0] data;
        logic [AW-1:0]    addr;
        logic             last;
        logic [7:0]       sym;
    } exp_t;

    typedef struct {
        int skip;
        int nsyms;
        int mode;
        int first;      // 1-based index of first symbol expected at the output
        int nout;
        int exp_level;  // -1: not checked
        bit exp_ovf;
        int exp_sym;
        bit gap_chk;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   out_words = 0;
    int   last_cyc = 0;
    bit   prev_last = 1'b0;
    bit   gap_chk_en = 1'b0;
    int   exp_sym = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NC*DW-1:0] mk_word(int sid, int n);
        logic [NC*DW-1:0] w;
        for (int k = 0; k < NC; k++) w[k*DW +: DW] = {16'(sid), 16'(k), 32'(n)};
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.o_tvalid) begin
            exp_t e;
            out_words++;
            if (gap_chk_en && prev_last) begin
                checks++;
                if (cyc - last_cyc - 1 > RL + 1) begin
                    errors++;
                    $display("FAIL sym_gap: got %0d idle cycles, want <= %0d", cyc - last_cyc - 1, RL + 1);
                end
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: addr=%0d sym=%0d, want no output", bus.o_tx_addr, bus.o_tx_sym);
            end else begin
                e = sb_q.pop_front();
                if (bus.o_tx_data !== e.data || bus.o_tx_addr !== e.addr ||
                    bus.o_tx_last !== e.last || bus.o_tx_sym !== e.sym) begin
                    errors++;
                    $display("FAIL out_word: got addr=%0d last=%0b sym=%0d data=%h, want addr=%0d last=%0b sym=%0d data=%h",
                             bus.o_tx_addr, bus.o_tx_last, bus.o_tx_sym, bus.o_tx_data,
                             e.addr, e.last, e.sym, e.data);
                end
            end
            prev_last = bus.o_tx_last;
            if (bus.o_tx_last) last_cyc = cyc;
        end
    end

    task automatic check_val(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
        else $display("check %s = %0d", name, got);
    endtask

    task automatic check_zero(string name);
        checks++;
        if (bus.o_tvalid !== 1'b0 || bus.o_tx_last !== 1'b0 || bus.o_overflow !== 1'b0 ||
            bus.o_level !== '0 || bus.o_tx_sym !== '0 || bus.o_tx_addr !== '0 || bus.o_tx_data !== '0) begin
            errors++;
            $display("FAIL %s: got tvalid=%0b last=%0b ovf=%0b level=%0d sym=%0d addr=%0d, want all 0",
                     name, bus.o_tvalid, bus.o_tx_last, bus.o_overflow, bus.o_level, bus.o_tx_sym, bus.o_tx_addr);
        end
        else $display("check %s: outputs zero", name);
    endtask

    task automatic do_reset(int skip);
        rst_n = 1'b0;
        bus.i_skip_syms = 4'(skip);
        bus.i_rvalid = 1'b0;
        bus.i_rready = 1'b0;
        bus.i_rx_data = '0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        sb_q.delete();
        out_words = 0;
        exp_sym = 0;
        prev_last = 1'b0;
        rst_n = 1'b1;
    endtask

    // One symbol followed by three idle cycles, which lets the reader keep pace.
    task automatic write_symbol(int sid, bit expect_out);
        for (int n = 0; n < SL; n++) begin
            @(negedge clk);
            bus.i_rvalid = 1'b1;
            bus.i_rx_data = mk_word(sid, n);
            if (expect_out) sb_q.push_back('{mk_word(sid, n), AW'(n), (n == SL - 1), 8'(exp_sym)});
        end
        if (expect_out) exp_sym++;
        @(negedge clk);
        bus.i_rvalid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_drain(bit toggle);
        for (int i = 0; i < 4 * SL + 200; i++) begin
            @(negedge clk);
            if (toggle) bus.i_rready = ~bus.i_rready;
            if (sb_q.size() == 0) break;
        end
        check_val("drain_pending_words", sb_q.size(), 0);
        repeat (8) @(negedge clk);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{0, 1, M_ON, 1, 1, 1, 1'b0, 1, 1'b0};
        tbl[1] = '{3, 5, M_ON, 4, 2, -1, 1'b0, 2, 1'b0};
        tbl[2] = '{0, 3, M_OFF, 1, 2, 2, 1'b1, 2, 1'b0};
        tbl[3] = '{0, 1, M_TOG, 1, 1, 1, 1'b0, 1, 1'b0};
        tbl[4] = '{0, 10, M_ON, 1, 10, -1, 1'b0, 10, 1'b1};

        bus.i_rx_data = '0;
        bus.i_rvalid = 1'b0;
        bus.i_skip_syms = '0;
        bus.i_rready = 1'b0;

        for (int r = 0; r < 5; r++) begin
            vec_t v;
            v = tbl[r];
            do_reset(v.skip);
            gap_chk_en = v.gap_chk;
            bus.i_rready = (v.mode == M_ON);
            for (int s = 1; s <= v.nsyms; s++)
                write_symbol(r * 16 + s, (s >= v.first) && (s < v.first + v.nout));
            if (v.exp_level >= 0) check_val("level_after_write", int'(bus.o_level), v.exp_level);
            if (v.mode == M_OFF) bus.i_rready = 1'b1;
            wait_drain(v.mode == M_TOG);
            check_val("final_sym", int'(bus.o_tx_sym), v.exp_sym);
            check_val("overflow", int'(bus.o_overflow), int'(v.exp_ovf));
            check_val("level_final", int'(bus.o_level), 0);
            check_val("word_count", out_words, v.nout * SL);
            gap_chk_en = 1'b0;
        end

        // Asynchronous reset in the middle of a symbol read.
        do_reset(0);
        bus.i_rready = 1'b1;
        write_symbol(200, 1'b1);
        for (int i = 0; i < 4 * SL && out_words < 700; i++) @(negedge clk);
        check_val("words_before_reset", int'(out_words >= 700), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset_mid_read");
        sb_q.delete();
        exp_sym = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_words = 0;
        prev_last = 1'b0;
        check_val("level_after_async_reset", int'(bus.o_level), 0);
        write_symbol(201, 1'b1);
        wait_drain(1'b0);
        check_val("sym_after_async_reset", int'(bus.o_tx_sym), 1);
        check_val("words_after_async_reset", out_words, SL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
